// File: rtl/ilm_iter_seq.sv
// rtl/ilm_iter_seq.sv - ILM iteration controller feeding MCLA_20_var; ILM_EXACT_EN iterates to an exact product
module ilm_iter_seq #(
    parameter int ITER_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] p,
    output logic [3:0]  n_iter,
    output logic [19:0] add_a,
    output logic [19:0] add_b,
    input  logic [19:0] add_s
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t      state, state_nx;
    logic [9:0]  x1, x2;
    logic [19:0] acc;
    logic [3:0]  cnt;
    logic [3:0]  k1, k2;
    logic [9:0]  r1, r2;
    logic [4:0]  ksum;
    logic [19:0] term;
    logic        last_term;

    function automatic logic [3:0] lod(input logic [9:0] v);
        lod = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) lod = 4'(i);
        end
    endfunction

    assign k1   = lod(x1);
    assign k2   = lod(x2);
    assign r1   = x1 - (10'd1 << k1);
    assign r2   = x2 - (10'd1 << k2);
    assign ksum = {1'b0, k1} + {1'b0, k2};
    assign term = (20'd1 << ksum) + ({10'd0, r1} << k2) + ({10'd0, r2} << k1);

`ifdef ILM_EXACT_EN
    assign last_term = (r1 == 10'd0) || (r2 == 10'd0);
`else
    assign last_term = (r1 == 10'd0) || (r2 == 10'd0) || (cnt == 4'(ITER_MAX - 1));
`endif

    // The accumulator doubles as the product register and adder operand A.
    assign p      = acc;
    assign n_iter = cnt;
    assign add_a  = acc;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_b     = 20'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (a == 10'd0 || b == 10'd0) ? DONE : ITER;
            end
            ITER: begin
                add_b = term;
                if (last_term) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x1    <= 10'd0;
            x2    <= 10'd0;
            acc   <= 20'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x1  <= a;
                        x2  <= b;
                        acc <= 20'd0;
                        cnt <= 4'd0;
                    end
                end
                ITER: begin
                    acc <= add_s;
                    x1  <= r1;
                    x2  <= r2;
                    cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ilm_iter_seq.sv
// tb/tb_ilm_iter_seq.sv - scoreboard bench for ilm_iter_seq at ITER_MAX=2 and ITER_MAX=1
module tb_ilm_iter_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  a = 10'd0;
    logic [9:0]  b = 10'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, in_ready1, out_valid1;
    logic [19:0] p, add_a, add_b, add_s, p1, add_a1, add_b1, add_s1;
    logic [3:0]  n_iter, n_iter1;

    int checks = 0;
    int errors = 0;
    logic term_chk = 1'b1;

    logic [19:0] qp[$];
    logic [3:0]  qn[$];
    logic [19:0] qp1[$];
    logic [3:0]  qn1[$];
    logic [19:0] tq[$];

    always #5 clk = ~clk;

    assign add_s  = add_a + add_b;
    assign add_s1 = add_a1 + add_b1;

    ilm_iter_seq #(.ITER_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .n_iter(n_iter), .add_a(add_a), .add_b(add_b), .add_s(add_s)
    );

    ilm_iter_seq #(.ITER_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .p(p1), .n_iter(n_iter1), .add_a(add_a1), .add_b(add_b1), .add_s(add_s1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever a product handshake or an ITER cycle is seen.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (qp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got product %0d expected none", p);
                end else begin
                    check("p", p, qp.pop_front());
                    check("n_iter", n_iter, qn.pop_front());
                end
            end
            if (out_valid1 && out_ready) begin
                if (qp1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb1_unexpected: got product %0d expected none", p1);
                end else begin
                    check("p_im1", p1, qp1.pop_front());
                    check("n_iter_im1", n_iter1, qn1.pop_front());
                end
            end
            if (!in_ready && !out_valid && term_chk) begin
                if (tq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL term_unexpected: got add_b %0d expected none", add_b);
                end else begin
                    check("add_b_term", add_b, tq.pop_front());
                end
            end
        end
    end

    task automatic run(input logic [9:0] va, input logic [9:0] vb,
                       input logic [19:0] ep, input logic [3:0] en,
                       input logic [19:0] ep1, input logic [3:0] en1,
                       input int lat, input int lat1, input int hold);
        int l0, l1;
        l0 = -1;
        l1 = -1;
        @(posedge clk); #1;
        check("in_ready_idle", in_ready, 1);
        a = va; b = vb; in_valid = 1'b1;
        qp.push_back(ep);   qn.push_back(en);
        qp1.push_back(ep1); qn1.push_back(en1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (l0 < 0 && out_valid)  l0 = c;
            if (l1 < 0 && out_valid1) l1 = c;
            if (l0 >= 0 && l1 >= 0) break;
            @(posedge clk); #1;
        end
        check("latency", l0, lat);
        check("latency_im1", l1, lat1);
        for (int h = 0; h < hold; h++) begin
            a = 10'd5; b = 10'd5; in_valid = 1'b1;
            check("hold_p", p, ep);
            check("hold_n_iter", n_iter, en);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        check("release_out_valid_im1", out_valid1, 0);
        check("release_in_ready_im1", in_ready1, 1);
    endtask

    initial begin
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        check("rst_n_iter", n_iter, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        #19 rst_n = 1'b1;

`ifdef ILM_EXACT_EN
        tq.push_back(20'd8); tq.push_back(20'd1);
        run(10'd3, 10'd3, 20'd9, 4'd2, 20'd9, 4'd2, 2, 2, 0);
        run(10'd0, 10'd517, 20'd0, 4'd0, 20'd0, 4'd0, 0, 0, 0);
        tq.push_back(20'd1600);
        run(10'd8, 10'd200, 20'd1600, 4'd1, 20'd1600, 4'd1, 1, 1, 5);
        term_chk = 1'b0;
        run(10'd1023, 10'd1023, 20'd1046529, 4'd10, 20'd1046529, 4'd10, 10, 10, 0);
        term_chk = 1'b1;
`else
        tq.push_back(20'd8); tq.push_back(20'd1);
        run(10'd3, 10'd3, 20'd9, 4'd2, 20'd8, 4'd1, 2, 1, 0);
        run(10'd0, 10'd517, 20'd0, 4'd0, 20'd0, 4'd0, 0, 0, 0);
        tq.push_back(20'd1600);
        run(10'd8, 10'd200, 20'd1600, 4'd1, 20'd1600, 4'd1, 1, 1, 5);
        tq.push_back(20'd785408); tq.push_back(20'd196096);
        run(10'd1023, 10'd1023, 20'd981504, 4'd2, 20'd785408, 4'd1, 2, 1, 0);
`endif

        // Reset during the second ITER cycle discards the pending product.
        tq.push_back(20'd785408);
        @(posedge clk); #1;
        a = 10'd1023; b = 10'd1023; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_p", p, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_n_iter", n_iter, 0);
        check("abort_add_b", add_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_terms_left", tq.size(), 0);

        tq.push_back(20'd8); tq.push_back(20'd1);
`ifdef ILM_EXACT_EN
        run(10'd3, 10'd3, 20'd9, 4'd2, 20'd9, 4'd2, 2, 2, 0);
`else
        run(10'd3, 10'd3, 20'd9, 4'd2, 20'd8, 4'd1, 2, 1, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", qp.size(), 0);
        check("sb1_drain", qp1.size(), 0);
        check("term_drain", tq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
